// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch stage (master) and the memory (slave).
// Handshake: the master raises mem_req with a stable mem_addr and holds both until the
// slave returns mem_ack for one cycle; mem_rdata is valid only in that ack cycle.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage of the multicycle RV32I core: PC, instruction register, memory read
// handshake with timeout, and combinational decode of the instruction fields.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_write,
  input  logic [31:0]       pc_next,
  fetch_unit_if.master      mem,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic [31:0]       old_pc,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic              busy,
  output logic              fetch_fault,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] pend;
  logic        pend_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      old_pc       <= 32'h0;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= 32'h0;
      busy         <= 1'b0;
      fetch_fault  <= 1'b0;
      cnt          <= 8'd0;
      pend         <= 32'h0;
      pend_v       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_write)    pc <= pc_next;
          else if (pend_v) pc <= pend;
          pend_v <= 1'b0;
          // The fetch address is latched from the current pc, so a same-edge
          // pc_write only affects the following instruction.
          if (fetch_req) begin
            if (pc[1:0] == 2'b00) begin
              state        <= WAIT;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= pc;
              busy         <= 1'b1;
              instr_valid  <= 1'b0;
              cnt          <= 8'd0;
            end else begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (pc_write) begin
            pend   <= pc_next;
            pend_v <= 1'b1;
          end
          if (mem.mem_ack) begin
            instr       <= mem.mem_rdata;
            old_pc      <= mem.mem_addr;
            instr_valid <= 1'b1;
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            pend_v      <= 1'b0;
            // A write on the completing edge is newer than any pending one.
            if (pc_write)    pc <= pc_next;
            else if (pend_v) pc <= pend;
          end else if (({1'b0, cnt} + 9'd1) == 9'(TIMEOUT)) begin
            state       <= FAULT;
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            fetch_fault <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign func3     = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign func7     = instr[31:25];
  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table of fetch transactions, directed corner sequences,
// and a randomized phase checked against a transaction-level model.
module tb_fetch_unit;
  localparam int          TMO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, fetch_req, pc_write;
  logic [31:0] pc_next;
  logic        instr_valid, busy, fetch_fault;
  logic [31:0] instr, pc, old_pc;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  state_dbg;

  fetch_unit_if mem_bus();

  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_write(pc_write),
    .pc_next(pc_next), .mem(mem_bus), .instr_valid(instr_valid), .instr(instr),
    .pc(pc), .old_pc(old_pc), .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .busy(busy), .fetch_fault(fetch_fault),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          waits;
    logic [31:0] word;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; fetch_req = 1'b0; pc_write = 1'b0; pc_next = 32'h0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // One complete fetch: load pc, request, stall for 'waits' cycles, then ack.
  task automatic run_fetch(input vec_t v);
    pc_write = 1'b1; pc_next = v.addr;
    step();
    pc_write = 1'b0;
    check("pc_load", pc, v.addr);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("req_first", {31'b0, mem_bus.mem_req}, 32'd1);
    check("busy_first", {31'b0, busy}, 32'd1);
    check("valid_cleared", {31'b0, instr_valid}, 32'd0);
    check("addr_first", mem_bus.mem_addr, v.addr);
    for (int w = 0; w < v.waits; w++) begin
      step();
      check("req_held", {31'b0, mem_bus.mem_req}, 32'd1);
      check("addr_held", mem_bus.mem_addr, v.addr);
    end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = v.word;
    step();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    check("valid_set", {31'b0, instr_valid}, 32'd1);
    check("req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
    check("instr", instr, v.word);
    check("old_pc", old_pc, v.addr);
    check("opcode", {25'b0, opcode}, {25'b0, v.opc});
    check("rd", {27'b0, rd}, {27'b0, v.rd});
    check("func3", {29'b0, func3}, {29'b0, v.f3});
    check("rs1", {27'b0, rs1}, {27'b0, v.rs1});
    check("rs2", {27'b0, rs2}, {27'b0, v.rs2});
    check("func7", {25'b0, func7}, {25'b0, v.f7});
  endtask

  // Transaction-level reference for the random phase.
  bit          m_busy, m_fault, m_valid, m_got;
  logic [31:0] m_pc, m_old, m_instr, m_addr;
  int          m_waited;
  logic [31:0] pend_q[$];

  task automatic model_reset();
    m_busy = 0; m_fault = 0; m_valid = 0; m_got = 0;
    m_pc = 32'h0; m_old = 32'h0; m_instr = NOP; m_addr = 32'h0; m_waited = 0;
    pend_q.delete();
    exp_q.delete();
  endtask

  task automatic model_edge();
    m_got = 0;
    if (reset) begin
      model_reset();
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_busy) begin
      if (pc_write) pend_q.push_back(pc_next);
      if (mem_bus.mem_ack) begin
        m_instr = mem_bus.mem_rdata;
        exp_q.push_back(mem_bus.mem_rdata);
        m_got   = 1;
        m_old   = m_addr;
        m_valid = 1;
        m_busy  = 0;
        if (pend_q.size() > 0) m_pc = pend_q[$];
        pend_q.delete();
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_busy  = 0;
          m_fault = 1;
        end
      end
    end else begin
      if (fetch_req) begin
        if (m_pc % 4 == 0) begin
          m_busy = 1; m_addr = m_pc; m_waited = 0; m_valid = 0;
        end else begin
          m_fault = 1;
        end
      end
      if (pc_write) m_pc = pc_next;
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 32'h0050_0093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5,  7'h00};
    vecs[1] = '{32'h0000_0004, 3, 32'h0020_81B3, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2,  7'h00};
    vecs[2] = '{32'h0000_0008, 1, 32'h4020_8233, 7'h33, 5'd4, 3'd0, 5'd1, 5'd2,  7'h20};
    vecs[3] = '{32'h0000_0100, 2, 32'h0081_2283, 7'h03, 5'd5, 3'd2, 5'd2, 5'd8,  7'h00};
    vecs[4] = '{32'h0000_FFFC, 0, 32'hFFF0_0113, 7'h13, 5'd2, 3'd0, 5'd0, 5'd31, 7'h7F};

    idle_inputs();
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_state", {30'b0, state_dbg}, 32'd0);

    for (int i = 0; i < 5; i++) run_fetch(vecs[i]);

    // pc_write while waiting is deferred; the last write wins.
    pc_write = 1'b1; pc_next = 32'h4;
    step();
    pc_write = 1'b0; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0; pc_write = 1'b1; pc_next = 32'h20;
    step();
    pc_next = 32'h8;
    check("pend_addr_stable", mem_bus.mem_addr, 32'h4);
    check("pend_pc_unchanged", pc, 32'h4);
    step();
    pc_write = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000_0013;
    step();
    mem_bus.mem_ack = 1'b0;
    check("pend_pc_applied", pc, 32'h8);
    check("pend_old_pc", old_pc, 32'h4);

    // Same-edge pc_write and fetch_req in IDLE: fetch uses the old pc.
    pc_write = 1'b1; pc_next = 32'h40; fetch_req = 1'b1;
    step();
    pc_write = 1'b0; fetch_req = 1'b0;
    check("simul_addr", mem_bus.mem_addr, 32'h8);
    check("simul_pc", pc, 32'h40);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5013;
    step();
    check("simul_old_pc", old_pc, 32'h8);
    check("simul_instr", instr, 32'h1234_5013);
    // Ack outside WAIT must not be latched.
    mem_bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_bus.mem_ack = 1'b0;
    check("stray_ack_instr", instr, 32'h1234_5013);
    check("stray_ack_valid", {31'b0, instr_valid}, 32'd1);

    // Misaligned pc faults without a memory request; fault is sticky until reset.
    pc_write = 1'b1; pc_next = 32'h6;
    step();
    pc_write = 1'b0; fetch_req = 1'b1;
    step();
    check("mis_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("mis_fault", {31'b0, fetch_fault}, 32'd1);
    pc_write = 1'b1; pc_next = 32'h0; mem_bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_req_ignored", {31'b0, mem_bus.mem_req}, 32'd0);
      check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    end
    check("fault_pc_frozen", pc, 32'h6);
    idle_inputs();
    do_reset();
    check("fault_cleared", {31'b0, fetch_fault}, 32'd0);
    check("fault_rst_pc", pc, 32'h0);

    // Timeout: fault appears after TMO wait cycles; a late ack is dropped.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      step();
      check("tmo_not_yet", {31'b0, fetch_fault}, 32'd0);
      check("tmo_req_held", {31'b0, mem_bus.mem_req}, 32'd1);
    end
    step();
    check("tmo_fault", {31'b0, fetch_fault}, 32'd1);
    check("tmo_req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    step();
    mem_bus.mem_ack = 1'b0;
    check("tmo_late_ack", instr, NOP);

    // Reset in the second wait cycle with a simultaneous ack; pending pc dropped.
    idle_inputs();
    do_reset();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0; pc_write = 1'b1; pc_next = 32'h80;
    step();
    pc_write = 1'b0; reset = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
    step();
    idle_inputs();
    check("rmid_pc", pc, 32'h0);
    check("rmid_instr", instr, NOP);
    check("rmid_valid", {31'b0, instr_valid}, 32'd0);
    check("rmid_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rmid_state", {30'b0, state_dbg}, 32'd0);
    step();
    check("rmid_pend_dropped", pc, 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [31:0] r;
      reset     = ($urandom_range(0, 24) == 0);
      fetch_req = ($urandom_range(0, 2) == 0);
      pc_write  = ($urandom_range(0, 3) == 0);
      r = $urandom();
      if ($urandom_range(0, 15) != 0) r[1:0] = 2'b00;
      pc_next = r;
      mem_bus.mem_ack   = ($urandom_range(0, 1) == 0);
      mem_bus.mem_rdata = $urandom();
      model_edge();
      step();
      check("rnd_pc", pc, m_pc);
      check("rnd_req", {31'b0, mem_bus.mem_req}, {31'b0, m_busy});
      check("rnd_busy", {31'b0, busy}, {31'b0, m_busy});
      check("rnd_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      check("rnd_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check("rnd_old_pc", old_pc, m_old);
      check("rnd_instr", instr, m_instr);
      if (m_busy) check("rnd_addr", mem_bus.mem_addr, m_addr);
      if (m_got && exp_q.size() > 0) check("rnd_sb_instr", instr, exp_q.pop_front());
    end

    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
